// File: rtl/pc_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pc_sequencer_pkg
// Description : Shared codes for the multi-cycle sequencer: FSM state
//               encoding, next-PC source selects and decoded opcodes.
// Revision    : 1.0 - initial release
// ============================================================================
package pc_sequencer_pkg;

  typedef enum logic [2:0] {
    S_IF   = 3'b000,
    S_ID   = 3'b001,
    S_EX   = 3'b010,
    S_MEM  = 3'b011,
    S_WB   = 3'b100,
    S_HALT = 3'b101
  } state_t;

  // Next-PC source selects, shared with the PC-next mux.
  localparam logic [1:0] PC_NEXT = 2'b00;
  localparam logic [1:0] PC_REL  = 2'b01;
  localparam logic [1:0] PC_ABS  = 2'b10;
  localparam logic [1:0] PC_HALT = 2'b11;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_JAL  = 6'b000011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_BNE  = 6'b000101;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_HALT = 6'b111111;

  function automatic logic is_mem_op(input logic [5:0] op);
    return (op == OP_LW) || (op == OP_SW);
  endfunction

endpackage
`default_nettype wire

// File: rtl/pc_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module      : pc_sequencer_if
// Description : Control/handshake bundle between the sequencer (master) and
//               the datapath and memories (slave).
// Revision    : 1.0 - initial release
// ============================================================================
interface pc_sequencer_if #(
  parameter int CNT_W = 32
);
  logic [5:0]       opcode;
  logic             zero;
  logic             imem_ack;
  logic             dmem_ack;
  logic             imem_req;
  logic             ir_we;
  logic             dmem_req;
  logic             dmem_we;
  logic             reg_we;
  logic             pc_we;
  logic [1:0]       pc_sel;
  logic             halted;
  logic             timeout;
  logic [CNT_W-1:0] retired;
  logic [2:0]       state;

  modport master (
    input  opcode, zero, imem_ack, dmem_ack,
    output imem_req, ir_we, dmem_req, dmem_we, reg_we, pc_we, pc_sel,
           halted, timeout, retired, state
  );

  modport slave (
    output opcode, zero, imem_ack, dmem_ack,
    input  imem_req, ir_we, dmem_req, dmem_we, reg_we, pc_we, pc_sel,
           halted, timeout, retired, state
  );
endinterface
`default_nettype wire

// File: rtl/pc_sequencer_wait_timer.sv
`default_nettype none
// ============================================================================
// Module      : pc_sequencer_wait_timer
// Description : Memory wait-state counter. Counts un-acked request cycles;
//               expired flags that the current cycle is the last one allowed.
// Revision    : 1.0 - initial release
// ============================================================================
module pc_sequencer_wait_timer #(
  parameter int MAX_WAIT = 15,
  parameter int WAIT_W   = 4
) (
  input  wire logic clk,
  input  wire logic RST,
  input  wire logic clr,
  input  wire logic en,
  output logic      expired
);
  logic [WAIT_W-1:0] count;

  // The cycle in which the count would reach MAX_WAIT is the final wait cycle;
  // an ack arriving in that cycle still wins.
  assign expired = (count == WAIT_W'(MAX_WAIT - 1));

  // Count un-acked cycles, clearing whenever no request is waiting.
  always_ff @(posedge clk or negedge RST) begin
    if (!RST)      count <= '0;
    else if (clr)  count <= '0;
    else if (en)   count <= count + WAIT_W'(1);
  end
endmodule
`default_nettype wire

// File: rtl/pc_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : pc_sequencer
// Description : Multi-cycle CPU control FSM. Sequences IF/ID/EX/MEM/WB,
//               drives PC load/select and memory handshakes, stalls on wait
//               states and halts on HALT or memory timeout.
// Revision    : 1.0 - initial release
// ============================================================================
module pc_sequencer
  import pc_sequencer_pkg::*;
#(
  parameter int MAX_WAIT = 15,
  parameter int WAIT_W   = 4,
  parameter int CNT_W    = 32
) (
  input  wire logic        clk,
  input  wire logic        RST,
  pc_sequencer_if.master   bus
);
  state_t           state_q, state_d;
  logic [5:0]       op_q;
  logic             timeout_q;
  logic [CNT_W-1:0] retired_q;

  logic       imem_req_c, ir_we_c, dmem_req_c, dmem_we_c, reg_we_c, pc_we_c;
  logic       halted_c, set_timeout, wait_en, expired;
  logic [1:0] pc_sel_c;

  // One timer serves both IF and MEM: only one request is outstanding at once.
  pc_sequencer_wait_timer #(
    .MAX_WAIT (MAX_WAIT),
    .WAIT_W   (WAIT_W)
  ) u_wait_timer (
    .clk     (clk),
    .RST     (RST),
    .clr     (!wait_en),
    .en      (wait_en),
    .expired (expired)
  );

  // State, latched opcode, sticky timeout and retired-instruction count.
  always_ff @(posedge clk or negedge RST) begin
    if (!RST) begin
      state_q   <= S_IF;
      op_q      <= '0;
      timeout_q <= 1'b0;
      retired_q <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == S_ID) op_q      <= bus.opcode;
      if (set_timeout)     timeout_q <= 1'b1;
      if (pc_we_c)         retired_q <= retired_q + CNT_W'(1);
    end
  end

  // Next-state and control decode; pc_sel stays HALT unless the PC loads.
  always_comb begin
    state_d     = state_q;
    imem_req_c  = 1'b0;
    ir_we_c     = 1'b0;
    dmem_req_c  = 1'b0;
    dmem_we_c   = 1'b0;
    reg_we_c    = 1'b0;
    pc_we_c     = 1'b0;
    pc_sel_c    = PC_HALT;
    halted_c    = 1'b0;
    set_timeout = 1'b0;
    wait_en     = 1'b0;
    case (state_q)
      S_IF: begin
        imem_req_c = 1'b1;
        if (bus.imem_ack) begin
          ir_we_c = 1'b1;
          state_d = S_ID;
        end else begin
          wait_en = 1'b1;
          if (expired) begin
            set_timeout = 1'b1;
            state_d     = S_HALT;
          end
        end
      end
      S_ID: begin
        // Decode from the live opcode; later states use the latched copy.
        case (bus.opcode)
          OP_HALT: state_d = S_HALT;
          OP_J: begin
            pc_we_c  = 1'b1;
            pc_sel_c = PC_ABS;
            state_d  = S_IF;
          end
          OP_JAL:  state_d = S_WB;
          default: state_d = S_EX;
        endcase
      end
      S_EX: begin
        if (op_q == OP_BEQ || op_q == OP_BNE) begin
          pc_we_c  = 1'b1;
          pc_sel_c = ((op_q == OP_BEQ) == bus.zero) ? PC_REL : PC_NEXT;
          state_d  = S_IF;
        end else if (is_mem_op(op_q)) begin
          state_d = S_MEM;
        end else begin
          state_d = S_WB;
        end
      end
      S_MEM: begin
        dmem_req_c = 1'b1;
        dmem_we_c  = (op_q == OP_SW);
        if (bus.dmem_ack) begin
          if (op_q == OP_SW) begin
            pc_we_c  = 1'b1;
            pc_sel_c = PC_NEXT;
            state_d  = S_IF;
          end else begin
            state_d = S_WB;
          end
        end else begin
          wait_en = 1'b1;
          if (expired) begin
            set_timeout = 1'b1;
            state_d     = S_HALT;
          end
        end
      end
      S_WB: begin
        // JAL writes the link register and jumps in the same cycle.
        reg_we_c = 1'b1;
        pc_we_c  = 1'b1;
        pc_sel_c = (op_q == OP_JAL) ? PC_ABS : PC_NEXT;
        state_d  = S_IF;
      end
      S_HALT:  halted_c = 1'b1;
      default: state_d  = S_HALT;
    endcase
  end

  // Control outputs are forced low for as long as reset is held.
  assign bus.imem_req = RST & imem_req_c;
  assign bus.ir_we    = RST & ir_we_c;
  assign bus.dmem_req = RST & dmem_req_c;
  assign bus.dmem_we  = RST & dmem_we_c;
  assign bus.reg_we   = RST & reg_we_c;
  assign bus.pc_we    = RST & pc_we_c;
  assign bus.pc_sel   = RST ? pc_sel_c : 2'b00;
  assign bus.halted   = RST & halted_c;
  assign bus.timeout  = timeout_q;
  assign bus.retired  = retired_q;
  assign bus.state    = state_q;
endmodule
`default_nettype wire

// File: tb/tb_pc_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_pc_sequencer
// Description : Directed self-checking bench for pc_sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pc_sequencer;
  // {state, imem_req, ir_we, dmem_req, dmem_we, reg_we, pc_we, pc_sel, halted}
  localparam logic [11:0] V_RST        = 12'b000_0_0_0_0_0_0_00_0;
  localparam logic [11:0] V_IF_WAIT    = 12'b000_1_0_0_0_0_0_11_0;
  localparam logic [11:0] V_IF_ACK     = 12'b000_1_1_0_0_0_0_11_0;
  localparam logic [11:0] V_ID         = 12'b001_0_0_0_0_0_0_11_0;
  localparam logic [11:0] V_ID_J       = 12'b001_0_0_0_0_0_1_10_0;
  localparam logic [11:0] V_EX         = 12'b010_0_0_0_0_0_0_11_0;
  localparam logic [11:0] V_EX_REL     = 12'b010_0_0_0_0_0_1_01_0;
  localparam logic [11:0] V_EX_NEXT    = 12'b010_0_0_0_0_0_1_00_0;
  localparam logic [11:0] V_MEM_RD     = 12'b011_0_0_1_0_0_0_11_0;
  localparam logic [11:0] V_MEM_SW     = 12'b011_0_0_1_1_0_0_11_0;
  localparam logic [11:0] V_MEM_SW_ACK = 12'b011_0_0_1_1_0_1_00_0;
  localparam logic [11:0] V_WB_NEXT    = 12'b100_0_0_0_0_1_1_00_0;
  localparam logic [11:0] V_WB_ABS     = 12'b100_0_0_0_0_1_1_10_0;
  localparam logic [11:0] V_HALT       = 12'b101_0_0_0_0_0_0_11_1;

  localparam logic [5:0] R = 6'b000000, J = 6'b000010, JAL = 6'b000011;
  localparam logic [5:0] BEQ = 6'b000100, BNE = 6'b000101, LW = 6'b100011;
  localparam logic [5:0] SW = 6'b101011, HLT = 6'b111111, ADDI = 6'b001000;

  logic clk = 1'b0;
  logic RST;
  int   checks = 0;
  int   failures = 0;

  pc_sequencer_if #(.CNT_W(32)) bus ();

  pc_sequencer #(
    .MAX_WAIT (15),
    .WAIT_W   (4),
    .CNT_W    (32)
  ) dut (
    .clk (clk),
    .RST (RST),
    .bus (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [11:0] ctrl();
    return {bus.state, bus.imem_req, bus.ir_we, bus.dmem_req, bus.dmem_we,
            bus.reg_we, bus.pc_we, bus.pc_sel, bus.halted};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drive one cycle's inputs after the falling edge, then check the controls.
  task automatic cyc(input string tag, input logic [5:0] op, input logic ia,
                     input logic da, input logic z, input logic [11:0] exp);
    @(negedge clk);
    bus.opcode   = op;
    bus.imem_ack = ia;
    bus.dmem_ack = da;
    bus.zero     = z;
    #1 chk(tag, 32'(ctrl()), 32'(exp));
  endtask

  task automatic quiet_inputs();
    bus.opcode = '0; bus.imem_ack = 1'b0; bus.dmem_ack = 1'b0; bus.zero = 1'b0;
  endtask

  initial begin
    RST = 1'b0;
    quiet_inputs();
    repeat (2) @(negedge clk);
    #1 chk("rst_ctrl", 32'(ctrl()), 32'(V_RST));
    chk("rst_retired", bus.retired, 32'd0);
    chk("rst_timeout", 32'(bus.timeout), 32'd0);
    @(negedge clk); RST = 1'b1;
    #1 chk("rel_if", 32'(ctrl()), 32'(V_IF_WAIT));

    // R-type, zero wait states
    cyc("r_if", R, 1, 0, 0, V_IF_ACK);
    cyc("r_id", R, 0, 0, 0, V_ID);
    cyc("r_ex", R, 0, 0, 0, V_EX);
    cyc("r_wb", R, 0, 0, 0, V_WB_NEXT);
    chk("r_ret_pre", bus.retired, 32'd0);

    // BEQ taken, then BNE not taken (zero=1 for both)
    cyc("beq_if", BEQ, 1, 0, 0, V_IF_ACK);
    chk("r_ret_post", bus.retired, 32'd1);
    cyc("beq_id", BEQ, 0, 0, 1, V_ID);
    cyc("beq_ex", BEQ, 0, 0, 1, V_EX_REL);
    cyc("bne_if", BNE, 1, 0, 1, V_IF_ACK);
    cyc("bne_id", BNE, 0, 0, 1, V_ID);
    cyc("bne_ex", BNE, 0, 0, 1, V_EX_NEXT);

    // LW with three memory wait cycles
    cyc("lw_if", LW, 1, 0, 0, V_IF_ACK);
    chk("br_ret", bus.retired, 32'd3);
    cyc("lw_id", LW, 0, 0, 0, V_ID);
    cyc("lw_ex", LW, 0, 0, 0, V_EX);
    for (int i = 0; i < 3; i++) cyc("lw_mem_wait", LW, 0, 0, 0, V_MEM_RD);
    cyc("lw_mem_ack", LW, 0, 1, 0, V_MEM_RD);
    cyc("lw_wb", LW, 0, 0, 0, V_WB_NEXT);

    // SW, zero wait
    cyc("sw_if", SW, 1, 0, 0, V_IF_ACK);
    chk("lw_ret", bus.retired, 32'd4);
    cyc("sw_id", SW, 0, 0, 0, V_ID);
    cyc("sw_ex", SW, 0, 0, 0, V_EX);
    cyc("sw_mem", SW, 0, 1, 0, V_MEM_SW_ACK);

    // JAL then J
    cyc("jal_if", JAL, 1, 0, 0, V_IF_ACK);
    cyc("jal_id", JAL, 0, 0, 0, V_ID);
    cyc("jal_wb", JAL, 0, 0, 0, V_WB_ABS);
    cyc("j_if", J, 1, 0, 0, V_IF_ACK);
    cyc("j_id", J, 0, 0, 0, V_ID_J);

    // I-type ALU op
    cyc("addi_if", ADDI, 1, 0, 0, V_IF_ACK);
    chk("j_ret", bus.retired, 32'd7);
    cyc("addi_id", ADDI, 0, 0, 0, V_ID);
    cyc("addi_ex", ADDI, 0, 0, 0, V_EX);
    cyc("addi_wb", ADDI, 0, 0, 0, V_WB_NEXT);

    // Ack in the 15th wait cycle still succeeds; then HALT opcode
    for (int i = 0; i < 14; i++) cyc("edge_if_wait", HLT, 0, 0, 0, V_IF_WAIT);
    cyc("edge_if_ack", HLT, 1, 0, 0, V_IF_ACK);
    cyc("halt_id", HLT, 0, 0, 0, V_ID);
    cyc("halt_state", HLT, 0, 0, 0, V_HALT);
    chk("halt_ret", bus.retired, 32'd8);
    chk("halt_timeout", 32'(bus.timeout), 32'd0);

    // Reset pulse out of HALT
    @(negedge clk); RST = 1'b0; quiet_inputs();
    #1 chk("rst2_ctrl", 32'(ctrl()), 32'(V_RST));
    chk("rst2_ret", bus.retired, 32'd0);
    @(negedge clk); RST = 1'b1;
    #1 chk("rel2_if", 32'(ctrl()), 32'(V_IF_WAIT));

    // Fetch timeout: 15 un-acked IF cycles including the one above
    for (int i = 0; i < 14; i++) cyc("to_if_wait", R, 0, 0, 0, V_IF_WAIT);
    cyc("to_halt", R, 0, 0, 0, V_HALT);
    chk("to_timeout", 32'(bus.timeout), 32'd1);
    cyc("to_ack_ignored", R, 1, 1, 0, V_HALT);
    cyc("to_still_halt", R, 1, 1, 0, V_HALT);

    @(negedge clk); RST = 1'b0; quiet_inputs();
    #1 chk("rst3_ctrl", 32'(ctrl()), 32'(V_RST));
    chk("rst3_timeout", 32'(bus.timeout), 32'd0);
    @(negedge clk); RST = 1'b1;
    #1 chk("rel3_if", 32'(ctrl()), 32'(V_IF_WAIT));

    // Reset in the middle of an SW memory handshake
    cyc("sw2_if", SW, 1, 0, 0, V_IF_ACK);
    cyc("sw2_id", SW, 0, 0, 0, V_ID);
    cyc("sw2_ex", SW, 0, 0, 0, V_EX);
    cyc("sw2_mem", SW, 0, 0, 0, V_MEM_SW);
    #2 RST = 1'b0;
    #1 chk("rst4_ctrl", 32'(ctrl()), 32'(V_RST));
    chk("rst4_ret", bus.retired, 32'd0);
    @(negedge clk); RST = 1'b1; bus.dmem_ack = 1'b1;
    #1 chk("rel4_if", 32'(ctrl()), 32'(V_IF_WAIT));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
Multi-cycle control FSM that sequences the PC / PC-next datapath and the instruction and data memory handshakes. It is built for the multi-cycle variant of the CPU. Each instruction runs through fetch, decode, execute, memory and writeback; the block decides when the PC register loads and which next-PC source it takes. It stalls on memory wait states and halts on the HALT opcode or on a memory timeout.

Parameters:
MAX_WAIT, 15, maximum cycles a memory request may stay un-acked before a timeout (1..2^WAIT_W-1)
WAIT_W, 4, width of the wait-state counter
CNT_W, 32, width of the retired-instruction counter

Ports:
clk  in  1  clock, all state updates on posedge
RST  in  1  asynchronous, active-low reset
opcode  in  6  instruction[31:26] from the IR
zero  in  1  ALU zero flag, valid during EX
imem_ack  in  1  instruction memory data valid
dmem_ack  in  1  data memory access complete
imem_req  out  1  instruction fetch request
ir_we  out  1  IR load strobe
dmem_req  out  1  data memory request
dmem_we  out  1  data memory write (sw)
reg_we  out  1  register file write enable
pc_we  out  1  PC register load enable
pc_sel  out  2  next-PC source: NextIns/RelJmp/AbsJmp/HALT
halted  out  1  FSM is in S_HALT
timeout  out  1  sticky: halt was caused by a memory timeout
retired  out  CNT_W  instructions completed
state  out  3  current state code, for debug

Behaviour:
- Opcode and pc_sel constants:
  - Opcodes: R=000000, J=000010, JAL=000011, BEQ=000100, BNE=000101, LW=100011, SW=101011, HALT=111111. Any other opcode is an I-type ALU op.
  - pc_sel: NextIns=00, RelJmp=01, AbsJmp=10, HALT=11.
- States: S_IF=000, S_ID=001, S_EX=010, S_MEM=011, S_WB=100, S_HALT=101. Codes 110 and 111 go to S_HALT with timeout=0.
- Reset (RST=0, any time, including mid-handshake):
  - state=S_IF, retired=0, timeout=0, wait counter=0, op_q=0.
  - All control outputs are 0 while RST=0.
  - After release, the first cycle is S_IF with imem_req=1.
- Outputs are combinational from state, op_q, zero and the ack inputs.
- Whenever pc_we=0, pc_sel=HALT(11) so the PC holds.
- S_IF:
  - imem_req=1.
  - If imem_ack=1: ir_we=1 in that same cycle; next state S_ID; wait counter clears.
  - Otherwise the wait counter increments. When it reaches MAX_WAIT with no ack: timeout<=1, go to S_HALT.
  - An ack in the same cycle the counter reaches MAX_WAIT counts as success.
- S_ID: one cycle, op_q<=opcode.
  - HALT: go to S_HALT.
  - J: pc_we=1, pc_sel=AbsJmp, go to S_IF.
  - JAL: go to S_WB.
  - Otherwise go to S_EX.
  - Decode uses the live opcode in this cycle and op_q in later states.
- S_EX: one cycle, zero is sampled here.
  - BEQ: pc_we=1; pc_sel=RelJmp if zero=1, else NextIns; go to S_IF.
  - BNE: pc_we=1; pc_sel=RelJmp if zero=0, else NextIns; go to S_IF.
  - LW/SW: go to S_MEM.
  - Otherwise go to S_WB.
- S_MEM:
  - dmem_req=1; dmem_we=1 for SW.
  - Waits for dmem_ack with the same timeout rule as S_IF.
  - On ack: SW drives pc_we=1, pc_sel=NextIns, go to S_IF. LW goes to S_WB.
- S_WB: reg_we=1, pc_we=1, go to S_IF.
  - pc_sel=AbsJmp for JAL (link write and jump in the same cycle), NextIns otherwise.
- S_HALT:
  - halted=1, pc_sel=HALT, all other strobes 0.
  - Exit only via RST; imem_ack and dmem_ack are ignored.
- retired increments by 1 on every cycle with pc_we=1 and wraps modulo 2^CNT_W. The HALT instruction is not counted.
- Latency with zero wait states:
  - J: 2 cycles
  - BEQ/BNE: 3 cycles
  - R/I-type ALU: 4 cycles
  - SW: 4 cycles
  - JAL: 3 cycles
  - LW: 5 cycles
  - Each memory wait cycle adds 1.
- Exactly one pc_we pulse per non-HALT instruction. imem_req and dmem_req are never high in the same cycle.

Decomposition:
- Shared header head.v: pc_sel codes (NextIns/RelJmp/AbsJmp/HALT, shared with the PC-next logic), opcode constants, state codes.
- One natural sub-module: wait_timer (WAIT_W counter with clear, enable and limit compare, producing expired). It is instantiated once and shared by S_IF and S_MEM, since only one request is ever active.

Test Plan:
- R-type, acks on first cycle -> state sequence IF,ID,EX,WB; reg_we and pc_we high in WB with pc_sel=00; retired 0->1 after 4 cycles.
- BEQ with zero=1, then BNE with zero=1 -> first: EX pc_sel=01, pc_we=1; second: pc_sel=00; 3 cycles each, retired=2.
- LW with dmem_ack delayed 3 cycles -> dmem_req high 4 cycles with dmem_we=0, then WB reg_we=1; total 8 cycles.
- JAL -> IF,ID,WB; WB shows reg_we=1, pc_we=1, pc_sel=10. J -> pc_we in ID with pc_sel=10, no EX.
- imem_ack held 0 with MAX_WAIT=15 -> halted=1 and timeout=1 after 15 cycles in IF, pc_sel=11; a later ack is ignored; RST pulse returns to IF with retired=0 and timeout=0.
- HALT opcode, then RST asserted during S_MEM of a prior SW with ack pending -> HALT: halted=1, retired unchanged. RST: all outputs 0 immediately (async); state=000 after release.
